input_event_encoder: RTL

//  Sits directly downstream of the button debouncer stage.

---
 rtl/input_event_encoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/input_event_encoder.sv
// Turns five debounced button levels into press / auto-repeat events tagged with
// the switch snapshot, queued in a small FIFO behind a valid/ready handshake.
module input_event_encoder #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        btnu_i,
  input  logic        btnd_i,
  input  logic        btnl_i,
  input  logic        btnr_i,
  input  logic        btnc_i,
  input  logic [15:0] sw_i,
  output logic        evt_valid_o,
  input  logic        evt_ready_i,
  output logic [2:0]  evt_code_o,
  output logic        evt_repeat_o,
  output logic [15:0] evt_sw_o,
  output logic        overflow_o
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W   = 20;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [PTR_W:0]   OCC_FULL    = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  function automatic logic [2:0] lowest_code(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [4:0]       prev_q, prev_d;
  logic [4:0]       pend_q, pend_d;
  state_e           state_q, state_d;
  logic [2:0]       trk_q, trk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_pend_q, rep_pend_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

  logic [4:0]       btn_s, rise_s, cand_s, low_mask_s;
  logic [7:0]       btn_ext_s;
  logic [2:0]       low_code_s;
  logic             full_s, empty_s, pop_s, push_s, press_push_s, rep_push_s, tick_s;
  logic [ENT_W-1:0] push_ent_s, head_s;
  logic [CNT_W-1:0] last_s;

  // Edge detection, push arbitration and repeat tracking
  always_comb begin
    btn_s      = {btnc_i, btnr_i, btnl_i, btnd_i, btnu_i};
    btn_ext_s  = {3'b000, btn_s};
    rise_s     = btn_s & ~prev_q;
    cand_s     = pend_q | rise_s;
    low_mask_s = cand_s & (~cand_s + 5'd1);
    low_code_s = lowest_code(cand_s);
    full_s     = (occ_q == OCC_FULL);
    empty_s    = (occ_q == '0);
    pop_s      = !empty_s && evt_ready_i;

    prev_d       = btn_s;
    pend_d       = cand_s;
    ovf_d        = ovf_q | (|(rise_s & pend_q));
    push_s       = 1'b0;
    press_push_s = 1'b0;
    rep_push_s   = 1'b0;
    push_ent_s   = '0;

    if (!full_s && (cand_s != 5'd0)) begin
      press_push_s = 1'b1;
      push_s       = 1'b1;
      push_ent_s   = {1'b0, low_code_s, sw_i};
      pend_d       = cand_s & ~low_mask_s;
    end else if (!full_s && rep_pend_q) begin
      rep_push_s = 1'b1;
      push_s     = 1'b1;
      push_ent_s = {1'b1, trk_q, sw_i};
    end else begin
      pend_d = cand_s;
    end

    state_d    = state_q;
    trk_d      = trk_q;
    cnt_d      = cnt_q;
    rep_pend_d = rep_pend_q & ~rep_push_s;
    tick_s     = 1'b0;
    last_s     = (state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;

    if (press_push_s) begin
      state_d = ST_DELAY;
      trk_d   = low_code_s;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_DELAY, ST_REPEAT: begin
          if (!btn_ext_s[trk_q]) begin
            state_d    = ST_IDLE;
            rep_pend_d = 1'b0;
            cnt_d      = '0;
          end else if (cnt_q == last_s) begin
            tick_s  = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A tick that finds a repeat still waiting is lost
    if (tick_s && rep_pend_d) begin
      ovf_d = 1'b1;
    end else if (tick_s) begin
      rep_pend_d = 1'b1;
    end else begin
      rep_pend_d = rep_pend_d;
    end

    wr_ptr_d = push_s ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   occ_d = occ_q - {{PTR_W{1'b0}}, 1'b1};
      default: occ_d = occ_q;
    endcase
  end

  // State, FIFO storage and sticky overflow
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q     <= 5'd0;
      pend_q     <= 5'd0;
      state_q    <= ST_IDLE;
      trk_q      <= 3'd0;
      cnt_q      <= '0;
      rep_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      trk_q      <= trk_d;
      cnt_q      <= cnt_d;
      rep_pend_q <= rep_pend_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      if (push_s) mem_q[wr_ptr_q] <= push_ent_s;
    end
  end

  // Head is masked when empty so idle outputs read zero
  always_comb begin
    head_s       = empty_s ? '0 : mem_q[rd_ptr_q];
    evt_valid_o  = !empty_s;
    evt_repeat_o = head_s[19];
    evt_code_o   = head_s[18:16];
    evt_sw_o     = head_s[15:0];
    overflow_o   = ovf_q;
  end

endmodule
